bus_cycle_responder: RTL and testbench
======================================

Name: bus_cycle_responder

Overview:
Parametrised cycle-termination engine for the 68030 local bus. It replaces fixed combinational DSACK/BERR selection with a clocked state machine per bus cycle, providing:
- per-region wait states and port size,
- pass-through of external (VME-side) acknowledges,
- a bus-timeout watchdog that raises BERR on hung cycles.

It sits between the address decoder's active-low region selects and the CPU's open-drain DSACK/BERR drivers in the top-level bus logic.

Parameters:
NUM_REGIONS, 4, number of locally terminated regions (RAM, ROM, serial, ...)
WAIT_WIDTH, 4, bits per region wait-state count (0..2^WAIT_WIDTH-1 clocks)
TIMEOUT_WIDTH, 10, width of watchdog counter
TIMEOUT_CYCLES, 1000, clocks from AS assertion to forced BERR; 0 disables watchdog

Ports:
clock  input  1  system clock (all state on rising edge)
reset  input  1  asynchronous, active-low reset
cpu_as  input  1  CPU address strobe, active-low, synchronous to clock
cpu_fc  input  3  CPU function code; 3'b111 = CPU space (IACK etc.)
region_select  input  NUM_REGIONS  active-low region selects from address decode
region_wait  input  NUM_REGIONS*WAIT_WIDTH  wait clocks per region, region i at [i*WAIT_WIDTH +: WAIT_WIDTH]
region_port  input  NUM_REGIONS*2  active-low DSACK pattern per region: 00=32-bit, 10=16-bit, 01=8-bit
ext_select  input  1  active-low; cycle is terminated externally (VME)
ext_dsack  input  2  active-low external acknowledge
ext_berr  input  1  active-low external bus error
cpu_dsack_out  output  2  active-low DSACK request to open-drain drivers
cpu_berr_out  output  1  active-low BERR request
timeout_pulse  output  1  active-high, one clock, on watchdog expiry
busy  output  1  active-high while a cycle is being handled (state != IDLE)

Behaviour:
- Reset (reset low, asynchronous) forces:
  - state IDLE, counters 0,
  - cpu_dsack_out=2'b11, cpu_berr_out=1, timeout_pulse=0, busy=0.
- Reset mid-cycle aborts with no acknowledge.
- All outputs are registered.
- States: IDLE, WAIT, ACK, EXT, ERR, HOLD.
- IDLE: on a clock with cpu_as=0, capture the target, then branch:
  - Target priority: lowest-index active region_select, then ext_select, else unmapped.
  - Region with wait=0 → ACK (DSACK visible 1 clock after AS sampled low).
  - Region with wait=N → WAIT, counter loaded with N.
  - ext_select → EXT.
  - Unmapped and cpu_fc!=3'b111 → ERR.
  - Unmapped and cpu_fc==3'b111 → HOLD with no termination (interrupt logic answers); watchdog still runs.
- WAIT: counter decrements each clock; on the clock counter==1 transition to ACK.
  - Wait of N clocks gives DSACK N+1 clocks after AS sampled.
- ACK: drive the captured region_port pattern on cpu_dsack_out; remain until cpu_as=1, then IDLE.
  - Outputs return to 11 on the following clock edge.
- EXT: cpu_dsack_out follows ext_dsack and cpu_berr_out follows ext_berr, each with one register stage.
  - If both are asserted in the same clock, pass both (retry semantics are left to the CPU).
  - Return to IDLE when cpu_as=1.
- ERR: cpu_berr_out=0, dsack=11 until cpu_as=1, then IDLE.
- HOLD: outputs inactive until cpu_as=1, then IDLE.
- Watchdog:
  - Counter clears in IDLE and increments every clock in WAIT/EXT/HOLD.
  - When it reaches TIMEOUT_CYCLES: go to ERR, pulse timeout_pulse for exactly one clock, and force the EXT dsack pass-through inactive.
  - The counter saturates and does not wrap.
  - TIMEOUT_CYCLES=0 disables it.
  - ACK and ERR states are not watched.
- AS negated early (in WAIT, EXT or HOLD): return to IDLE next clock; no DSACK or BERR is ever issued for that cycle.
- Back-to-back cycles: at least one clock in IDLE with outputs inactive between cycles; AS low again in that IDLE clock starts the new cycle.
- Region selects changing after capture are ignored until the next cycle.

Decomposition:
- Shared package/header holds:
  - ACTIVE/INACTIVE constants,
  - DSACK encodings (DSACK_32=2'b00, DSACK_16=2'b10, DSACK_8=2'b01, DSACK_NONE=2'b11),
  - FC_CPU_SPACE=3'b111,
  - state encodings.
- One natural sub-module: bus_watchdog (saturating counter with clear, enable, and one-shot expiry pulse), reusable for VME arbitration timeout.

Test Plan:
- Region 1, wait=0, port=10; AS low at edge k → cpu_dsack_out=10 from edge k+1; AS high at edge m → 11 at edge m+1, busy=0.
- Region 0, wait=3, port=00 → dsack=00 exactly 4 clocks after AS sampled low; with regions 0 and 2 both selected, region 0's timing and port are used.
- Unmapped, fc=3'b101 → cpu_berr_out=0 one clock after AS low. Unmapped, fc=3'b111 → no DSACK/BERR until AS high, busy=1 throughout.
- ext_select low, ext_dsack=00 after 7 clocks → cpu_dsack_out=00 one clock later. Same setup with ext_berr=0 → cpu_berr_out=0 one clock later.
- ext_select low and never acknowledged, TIMEOUT_CYCLES=16 → BERR and a single timeout_pulse 16 clocks after AS sampled. Repeat with TIMEOUT_CYCLES=0 → no BERR after 2000 clocks.
- Assert reset mid-WAIT → outputs inactive immediately, no DSACK after reset release. AS negated during WAIT → no DSACK, next cycle normal.

Source files
------------

// File: rtl/bus_cycle_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_cycle_responder_pkg
// Description : Shared constants and state encoding for the 68030 bus cycle
//               termination engine.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_cycle_responder_pkg;

  localparam logic ACTIVE   = 1'b0;
  localparam logic INACTIVE = 1'b1;

  localparam logic [1:0] DSACK_32   = 2'b00;
  localparam logic [1:0] DSACK_16   = 2'b10;
  localparam logic [1:0] DSACK_8    = 2'b01;
  localparam logic [1:0] DSACK_NONE = 2'b11;

  localparam logic [2:0] FC_CPU_SPACE = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ACK  = 3'd2,
    ST_EXT  = 3'd3,
    ST_ERR  = 3'd4,
    ST_HOLD = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bus_cycle_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_cycle_responder_if
// Description : CPU-side bus signals seen by the cycle responder; all strobes
//               and acknowledges are active-low.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_cycle_responder_if #(
  parameter int NUM_REGIONS = 4,
  parameter int WAIT_WIDTH  = 4
);
  logic                              cpu_as;
  logic [2:0]                        cpu_fc;
  logic [NUM_REGIONS-1:0]            region_select;
  logic [NUM_REGIONS*WAIT_WIDTH-1:0] region_wait;
  logic [NUM_REGIONS*2-1:0]          region_port;
  logic                              ext_select;
  logic [1:0]                        ext_dsack;
  logic                              ext_berr;
  logic [1:0]                        cpu_dsack_out;
  logic                              cpu_berr_out;
  logic                              timeout_pulse;
  logic                              busy;

  modport slave (
    input  cpu_as, cpu_fc, region_select, region_wait, region_port,
           ext_select, ext_dsack, ext_berr,
    output cpu_dsack_out, cpu_berr_out, timeout_pulse, busy
  );

  modport master (
    output cpu_as, cpu_fc, region_select, region_wait, region_port,
           ext_select, ext_dsack, ext_berr,
    input  cpu_dsack_out, cpu_berr_out, timeout_pulse, busy
  );
endinterface
`default_nettype wire

// File: rtl/bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : bus_watchdog
// Description : Saturating cycle watchdog with clear/enable; expire is high
//               for the single enabled clock on which the count reaches LIMIT.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_watchdog #(
  parameter int WIDTH = 10,
  parameter int LIMIT = 1000
) (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic clear,
  input  wire logic enable,
  output logic      expire
);

  localparam bit               c_ENABLED = (LIMIT != 0);
  localparam logic [WIDTH-1:0] c_LIMIT   = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] c_LAST    = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && c_ENABLED && (count_q != c_LIMIT)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  assign expire = c_ENABLED && enable && !clear && (count_q == c_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_cycle_responder.sv
`default_nettype none
// ============================================================================
// Module      : bus_cycle_responder
// Description : Clocked DSACK/BERR termination engine for 68030 bus cycles with
//               per-region wait states, external pass-through and watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_cycle_responder
  import bus_cycle_responder_pkg::*;
#(
  parameter int NUM_REGIONS    = 4,
  parameter int WAIT_WIDTH     = 4,
  parameter int TIMEOUT_WIDTH  = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  wire logic              clock,
  input  wire logic              reset,
  bus_cycle_responder_if.slave   bus
);

  state_t                state_q, state_d;
  logic [WAIT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]            port_q, port_d;
  logic [1:0]            dsack_q, dsack_d;
  logic                  berr_q, berr_d;
  logic                  pulse_q, pulse_d;
  logic                  busy_q, busy_d;

  logic                  sel_found;
  logic [WAIT_WIDTH-1:0] sel_wait;
  logic [1:0]            sel_port;
  logic                  as_negated;
  logic                  wd_clear, wd_enable, wd_expire;
  logic                  timeout_hit;

  // Scan downwards so the lowest-index asserted select is the one left standing.
  always_comb begin
    sel_found = 1'b0;
    sel_wait  = '0;
    sel_port  = DSACK_NONE;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (bus.region_select[i] == ACTIVE) begin
        sel_found = 1'b1;
        sel_wait  = bus.region_wait[i*WAIT_WIDTH +: WAIT_WIDTH];
        sel_port  = bus.region_port[i*2 +: 2];
      end
    end
  end

  assign as_negated  = (bus.cpu_as == INACTIVE);
  assign wd_clear    = (state_q == ST_IDLE);
  assign wd_enable   = (state_q == ST_WAIT) || (state_q == ST_EXT) || (state_q == ST_HOLD);
  // A cycle the CPU has already abandoned never gets a timeout BERR.
  assign timeout_hit = wd_expire && !as_negated;

  bus_watchdog #(
    .WIDTH (TIMEOUT_WIDTH),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    port_d     = port_q;
    case (state_q)
      ST_IDLE: begin
        if (!as_negated) begin
          if (sel_found) begin
            port_d     = sel_port;
            wait_cnt_d = sel_wait;
            state_d    = (sel_wait == '0) ? ST_ACK : ST_WAIT;
          end else if (bus.ext_select == ACTIVE) begin
            state_d = ST_EXT;
          end else if (bus.cpu_fc == FC_CPU_SPACE) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_WAIT: begin
        if (as_negated) begin
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          state_d = ST_ERR;
        end else if (wait_cnt_q == WAIT_WIDTH'(1)) begin
          state_d = ST_ACK;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_WIDTH'(1);
        end
      end
      ST_EXT, ST_HOLD: begin
        if (as_negated) begin
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_ACK, ST_ERR: begin
        if (as_negated) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are a registered function of the state held during the clock.
  always_comb begin
    dsack_d = DSACK_NONE;
    berr_d  = INACTIVE;
    pulse_d = timeout_hit;
    busy_d  = (state_q != ST_IDLE);
    if (state_q == ST_ACK) begin
      dsack_d = port_q;
    end
    if ((state_q == ST_ERR) || timeout_hit) begin
      berr_d = ACTIVE;
    end
    if ((state_q == ST_EXT) && !as_negated && !timeout_hit) begin
      dsack_d = bus.ext_dsack;
      berr_d  = bus.ext_berr;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      port_q     <= DSACK_NONE;
      dsack_q    <= DSACK_NONE;
      berr_q     <= INACTIVE;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      port_q     <= port_d;
      dsack_q    <= dsack_d;
      berr_q     <= berr_d;
      pulse_q    <= pulse_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.cpu_dsack_out = dsack_q;
  assign bus.cpu_berr_out  = berr_q;
  assign bus.timeout_pulse = pulse_q;
  assign bus.busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_cycle_responder
// Description : Self-checking bench; two responders (watchdog 16 and disabled)
//               share stimulus and are compared against a cycle-timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_cycle_responder;

  localparam int NR = 4;
  localparam int WW = 4;
  localparam int K_REG  = 0;
  localparam int K_EXT  = 1;
  localparam int K_ERR  = 2;
  localparam int K_HOLD = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic chk_on = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  bus_cycle_responder_if #(.NUM_REGIONS(NR), .WAIT_WIDTH(WW)) bus_a ();
  bus_cycle_responder_if #(.NUM_REGIONS(NR), .WAIT_WIDTH(WW)) bus_b ();

  assign bus_b.cpu_as        = bus_a.cpu_as;
  assign bus_b.cpu_fc        = bus_a.cpu_fc;
  assign bus_b.region_select = bus_a.region_select;
  assign bus_b.region_wait   = bus_a.region_wait;
  assign bus_b.region_port   = bus_a.region_port;
  assign bus_b.ext_select    = bus_a.ext_select;
  assign bus_b.ext_dsack     = bus_a.ext_dsack;
  assign bus_b.ext_berr      = bus_a.ext_berr;

  bus_cycle_responder #(
    .NUM_REGIONS(NR), .WAIT_WIDTH(WW), .TIMEOUT_WIDTH(10), .TIMEOUT_CYCLES(16)
  ) dut_a (.clock(clock), .reset(reset), .bus(bus_a));

  bus_cycle_responder #(
    .NUM_REGIONS(NR), .WAIT_WIDTH(WW), .TIMEOUT_WIDTH(10), .TIMEOUT_CYCLES(0)
  ) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  // Model: each cycle is a timeline measured in clocks since AS was captured.
  bit         in_cyc [2];
  int         kind   [2];
  int         age    [2];
  int         wd     [2];
  int         mwait  [2];
  logic [1:0] mport  [2];
  logic [1:0] e_dsack[2];
  logic       e_berr [2];
  logic       e_pulse[2];
  logic       e_busy [2];

  task automatic model_reset(input int m);
    in_cyc[m] = 1'b0; kind[m] = K_HOLD; age[m] = 0; wd[m] = 0;
    e_dsack[m] = 2'b11; e_berr[m] = 1'b1; e_pulse[m] = 1'b0; e_busy[m] = 1'b0;
  endtask

  task automatic model_step(input int m, input int tmo);
    bit waiting, expire, found;
    e_dsack[m] = 2'b11; e_berr[m] = 1'b1; e_pulse[m] = 1'b0; e_busy[m] = in_cyc[m];
    if (!in_cyc[m]) begin
      if (bus_a.cpu_as == 1'b0) begin
        in_cyc[m] = 1'b1; age[m] = 0; wd[m] = 0; found = 1'b0;
        for (int i = 0; i < NR; i++) begin
          if (!found && bus_a.region_select[i] == 1'b0) begin
            found = 1'b1;
            mwait[m] = int'(bus_a.region_wait[i*WW +: WW]);
            mport[m] = bus_a.region_port[i*2 +: 2];
          end
        end
        if (found)                          kind[m] = K_REG;
        else if (bus_a.ext_select == 1'b0)  kind[m] = K_EXT;
        else if (bus_a.cpu_fc == 3'b111)    kind[m] = K_HOLD;
        else                                kind[m] = K_ERR;
      end
    end else begin
      age[m]++;
      waiting = (kind[m] == K_REG && age[m] - 1 < mwait[m]) || kind[m] == K_EXT || kind[m] == K_HOLD;
      expire  = (tmo != 0) && waiting && (bus_a.cpu_as == 1'b0) && (wd[m] == tmo - 1);
      if (kind[m] == K_REG && age[m] - 1 >= mwait[m]) e_dsack[m] = mport[m];
      if (kind[m] == K_ERR) e_berr[m] = 1'b0;
      if (kind[m] == K_EXT && bus_a.cpu_as == 1'b0 && !expire) begin
        e_dsack[m] = bus_a.ext_dsack;
        e_berr[m]  = bus_a.ext_berr;
      end
      if (expire) begin
        e_berr[m] = 1'b0; e_pulse[m] = 1'b1;
      end
      if (waiting) wd[m]++;
      if (bus_a.cpu_as == 1'b1) in_cyc[m] = 1'b0;
      else if (expire)          kind[m]   = K_ERR;
    end
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge clock or negedge reset);
      for (int m = 0; m < 2; m++) begin
        if (!reset) model_reset(m);
        else        model_step(m, (m == 0) ? 16 : 0);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (reset && chk_on) begin
        chk("a_dsack", 32'(bus_a.cpu_dsack_out), 32'(e_dsack[0]));
        chk("a_berr",  32'(bus_a.cpu_berr_out),  32'(e_berr[0]));
        chk("a_pulse", 32'(bus_a.timeout_pulse), 32'(e_pulse[0]));
        chk("a_busy",  32'(bus_a.busy),          32'(e_busy[0]));
        chk("b_dsack", 32'(bus_b.cpu_dsack_out), 32'(e_dsack[1]));
        chk("b_berr",  32'(bus_b.cpu_berr_out),  32'(e_berr[1]));
        chk("b_pulse", 32'(bus_b.timeout_pulse), 32'(e_pulse[1]));
        chk("b_busy",  32'(bus_b.busy),          32'(e_busy[1]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic idle_bus();
    bus_a.cpu_as = 1'b1; bus_a.region_select = 4'hF;
    bus_a.ext_select = 1'b1; bus_a.ext_dsack = 2'b11; bus_a.ext_berr = 1'b1;
  endtask

  task automatic rand_cycle();
    int   len, ack_at, gap;
    logic [3:0] sel;
    logic [1:0] ports [3];
    logic [7:0] pv;
    ports[0] = 2'b00; ports[1] = 2'b10; ports[2] = 2'b01;
    len    = $urandom_range(1, 24);
    ack_at = $urandom_range(0, 30);
    gap    = $urandom_range(1, 3);
    sel    = 4'($urandom());
    if ($urandom_range(0, 2) == 0) sel = 4'hF;
    for (int i = 0; i < NR; i++) pv[i*2 +: 2] = ports[$urandom_range(0, 2)];
    bus_a.region_port   = pv;
    bus_a.region_wait   = 16'($urandom());
    bus_a.region_select = sel;
    bus_a.ext_select    = 1'($urandom_range(0, 1));
    bus_a.cpu_fc        = ($urandom_range(0, 2) == 0) ? 3'b111 : 3'($urandom());
    bus_a.cpu_as        = 1'b0;
    for (int t = 0; t < len; t++) begin
      tick(1);
      if (t == 0 && $urandom_range(0, 3) == 0) bus_a.region_select = 4'($urandom());
      if (t == ack_at) begin
        bus_a.ext_dsack = ports[$urandom_range(0, 2)];
        bus_a.ext_berr  = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      end
    end
    idle_bus();
    tick(gap);
  endtask

  int bad;
  int extra;

  initial begin
    idle_bus();
    bus_a.cpu_fc = 3'b000; bus_a.region_wait = '0; bus_a.region_port = '0;

    tick(3);
    chk("rst_dsack", 32'(bus_a.cpu_dsack_out), 32'h3);
    chk("rst_berr",  32'(bus_a.cpu_berr_out),  32'h1);
    chk("rst_pulse", 32'(bus_a.timeout_pulse), 32'h0);
    chk("rst_busy",  32'(bus_a.busy),          32'h0);
    reset = 1'b1; chk_on = 1'b1;
    tick(2);

    // Region 1, zero wait, 16-bit port
    bus_a.region_wait = 16'h0000; bus_a.region_port = 8'b0000_1000;
    bus_a.region_select = 4'b1101; bus_a.cpu_as = 1'b0;
    tick(1); chk("r1_edge_k",  32'(bus_a.cpu_dsack_out), 32'h3);
    tick(1); chk("r1_edge_k1", 32'(bus_a.cpu_dsack_out), 32'h2);
    idle_bus();
    tick(1); chk("r1_edge_m",  32'(bus_a.cpu_dsack_out), 32'h2);
    tick(1); chk("r1_edge_m1", 32'(bus_a.cpu_dsack_out), 32'h3);
    chk("r1_busy_end", 32'(bus_a.busy), 32'h0);

    // Regions 0 and 2 both selected: region 0 (wait 3, 32-bit) wins
    bus_a.region_wait = 16'h0003; bus_a.region_port = 8'b0001_0000;
    bus_a.region_select = 4'b1010; bus_a.cpu_as = 1'b0;
    tick(2); chk("r0_prio_t2", 32'(bus_a.cpu_dsack_out), 32'h3);
    tick(2); chk("r0_prio_t4", 32'(bus_a.cpu_dsack_out), 32'h3);
    tick(1); chk("r0_prio_t5", 32'(bus_a.cpu_dsack_out), 32'h0);
    idle_bus(); tick(2);

    // Unmapped, data space
    bus_a.cpu_fc = 3'b101; bus_a.cpu_as = 1'b0;
    tick(1); chk("unm_t1", 32'(bus_a.cpu_berr_out), 32'h1);
    tick(1); chk("unm_t2", 32'(bus_a.cpu_berr_out), 32'h0);
    idle_bus(); tick(2);
    chk("unm_end", 32'(bus_a.cpu_berr_out), 32'h1);

    // Unmapped, CPU space
    bus_a.cpu_fc = 3'b111; bus_a.cpu_as = 1'b0;
    tick(10);
    chk("hold_dsack", 32'(bus_a.cpu_dsack_out), 32'h3);
    chk("hold_berr",  32'(bus_a.cpu_berr_out),  32'h1);
    chk("hold_busy",  32'(bus_a.busy),          32'h1);
    idle_bus(); tick(2);
    chk("hold_end_busy", 32'(bus_a.busy), 32'h0);
    bus_a.cpu_fc = 3'b001;

    // External acknowledge and external bus error
    bus_a.ext_select = 1'b0; bus_a.cpu_as = 1'b0;
    tick(7); bus_a.ext_dsack = 2'b00;
    tick(1); chk("ext_dsack", 32'(bus_a.cpu_dsack_out), 32'h0);
    idle_bus(); tick(2);
    bus_a.ext_select = 1'b0; bus_a.cpu_as = 1'b0;
    tick(7); bus_a.ext_berr = 1'b0;
    tick(1); chk("ext_berr", 32'(bus_a.cpu_berr_out), 32'h0);
    idle_bus(); tick(2);

    // Hung external cycle: watchdog 16 versus disabled
    bus_a.ext_select = 1'b0; bus_a.cpu_as = 1'b0;
    tick(16);
    chk("wd_t16_pulse", 32'(bus_a.timeout_pulse), 32'h0);
    chk("wd_t16_berr",  32'(bus_a.cpu_berr_out),  32'h1);
    tick(1);
    chk("wd_t17_pulse", 32'(bus_a.timeout_pulse), 32'h1);
    chk("wd_t17_berr",  32'(bus_a.cpu_berr_out),  32'h0);
    chk("wd_t17_dsack", 32'(bus_a.cpu_dsack_out), 32'h3);
    tick(1);
    chk("wd_t18_pulse", 32'(bus_a.timeout_pulse), 32'h0);
    bad = 0; extra = 0;
    for (int i = 0; i < 1990; i++) begin
      tick(1);
      if (bus_b.cpu_berr_out == 1'b0 || bus_b.timeout_pulse == 1'b1) bad++;
      if (bus_a.timeout_pulse == 1'b1) extra++;
    end
    chk("wd_off_no_berr", 32'(bad), 32'h0);
    chk("wd_single_pulse", 32'(extra), 32'h0);
    idle_bus(); tick(2);

    // Reset in the middle of a wait-state cycle
    bus_a.region_wait = 16'h00A0; bus_a.region_port = 8'b0000_0000;
    bus_a.region_select = 4'b1101; bus_a.cpu_as = 1'b0;
    tick(3); chk("rstw_busy_pre", 32'(bus_a.busy), 32'h1);
    #2 reset = 1'b0;
    #1 chk("rstw_busy_now",  32'(bus_a.busy), 32'h0);
    chk("rstw_dsack_now", 32'(bus_a.cpu_dsack_out), 32'h3);
    idle_bus();
    @(negedge clock); reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      if (bus_a.cpu_dsack_out != 2'b11) bad++;
    end
    chk("rstw_no_dsack", 32'(bad), 32'h0);

    // AS negated during wait states, then a normal cycle
    bus_a.region_wait = 16'h0080; bus_a.region_port = 8'b0000_0100;
    bus_a.region_select = 4'b1101; bus_a.cpu_as = 1'b0;
    tick(3); idle_bus();
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (bus_a.cpu_dsack_out != 2'b11 || bus_a.cpu_berr_out != 1'b1) bad++;
    end
    chk("early_neg_no_ack", 32'(bad), 32'h0);
    bus_a.region_wait = 16'h0000; bus_a.region_port = 8'b0000_1000;
    bus_a.region_select = 4'b1101; bus_a.cpu_as = 1'b0;
    tick(2); chk("after_neg_dsack", 32'(bus_a.cpu_dsack_out), 32'h2);
    idle_bus(); tick(2);

    for (int n = 0; n < 150; n++) rand_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
